cpu_step_ctrl: RTL and testbench

//   Sits directly downstream of the clock divider. Converts its slow toggle output into single-cycle
//   CPU clock-enable pulses in the main clk domain (no derived clocks). Adds front-panel run/halt and

---
 rtl/cpu_step_ctrl_pkg.sv | 11 +
 rtl/cpu_step_ctrl_debounce.sv | 50 +++++
 rtl/cpu_step_ctrl.sv | 125 ++++++++++++
 tb/tb_cpu_step_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the CPU clock-enable / single-step controller.
// State encodings are also used by the debug and LED logic.
package cpu_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

endpackage

// File: rtl/cpu_step_ctrl_debounce.sv
// Front-panel button conditioner: 2-flop synchroniser, stability counter,
// and a single-cycle pulse on each debounced press (release is silent).
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          btn_meta_r;
  logic          btn_sync_r;
  logic          level_r;
  logic [CW-1:0] count_r;
  logic          press_r;

  // Synchronise, then flip the level after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
      level_r    <= 1'b0;
      count_r    <= {CW{1'b0}};
      press_r    <= 1'b0;
    end else begin
      btn_meta_r <= btn;
      btn_sync_r <= btn_meta_r;
      press_r    <= 1'b0;
      if (btn_sync_r != level_r) begin
        if (count_r == CNT_LAST) begin
          level_r <= ~level_r;
          count_r <= {CW{1'b0}};
          press_r <= ~level_r;
        end else begin
          count_r <= count_r + CNT_ONE;
        end
      end else begin
        count_r <= {CW{1'b0}};
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Turns the divider's slow toggle into single-cycle CPU clock enables in the clk
// domain, with run/halt switch, debounced single-step, and CPU HLT handling.
import cpu_step_ctrl_pkg::*;

module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             cpu_ce,
  output logic             running,
  output logic             cpu_halted,
  output logic [CNT_W-1:0] ce_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             slow_q_r;
  logic             run_meta_r;
  logic             run_sync_r;
  logic             cpu_ce_r;
  logic             running_r;
  logic             halted_r;
  logic [CNT_W-1:0] ce_count_r;
  logic             tick_s;
  logic             step_req_s;
  logic             ce_nxt_s;
  logic             halted_nxt_s;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (step_btn),
    .press (step_req_s)
  );

  assign tick_s = slow_clk & ~slow_q_r;

  // Next-state, enable and sticky-halt decisions from current state and tick
  always_comb begin
    state_nxt_s  = state_r;
    ce_nxt_s     = 1'b0;
    // Seeing the run switch low is what re-arms the controller after a HLT
    if (!run_sync_r) begin
      halted_nxt_s = 1'b0;
    end else begin
      halted_nxt_s = halted_r;
    end
    case (state_r)
      ST_HALT: begin
        if (step_req_s) begin
          state_nxt_s  = ST_STEP;
          halted_nxt_s = 1'b0;
        end else if (run_sync_r && !halted_r && !halt_req) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_nxt_s  = ST_HALT;
          halted_nxt_s = 1'b1;
        end else if (!run_sync_r) begin
          state_nxt_s = ST_HALT;
        end else begin
          ce_nxt_s = tick_s;
        end
      end
      ST_STEP: begin
        if (tick_s) begin
          ce_nxt_s    = 1'b1;
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_STEP;
        end
      end
      default: begin
        state_nxt_s = ST_HALT;
      end
    endcase
  end

  // State register, synchronisers and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_HALT;
      slow_q_r   <= 1'b0;
      run_meta_r <= 1'b0;
      run_sync_r <= 1'b0;
      cpu_ce_r   <= 1'b0;
      running_r  <= 1'b0;
      halted_r   <= 1'b0;
      ce_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      slow_q_r   <= slow_clk;
      run_meta_r <= run_sw;
      run_sync_r <= run_meta_r;
      cpu_ce_r   <= ce_nxt_s;
      running_r  <= (state_nxt_s == ST_RUN);
      halted_r   <= halted_nxt_s;
      if (cpu_ce_r) begin
        ce_count_r <= ce_count_r + CNT_ONE;
      end else begin
        ce_count_r <= ce_count_r;
      end
    end
  end

  assign cpu_ce     = cpu_ce_r;
  assign running    = running_r;
  assign cpu_halted = halted_r;
  assign ce_count   = ce_count_r;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl: stimulus queues each expected cpu_ce pulse,
// a monitor pops one per observed pulse and checks its timing and ce_count.
module tb_cpu_step_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          slow_clk;
  logic          run_sw;
  logic          step_btn;
  logic          halt_req;
  logic          cpu_ce;
  logic          running;
  logic          cpu_halted;
  logic [CW-1:0] ce_count;

  typedef struct {
    int            cyc;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            checks;
  int            errors;
  int            cyc;
  logic [CW-1:0] exp_count;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .slow_clk  (slow_clk),
    .run_sw    (run_sw),
    .step_btn  (step_btn),
    .halt_req  (halt_req),
    .cpu_ce    (cpu_ce),
    .running   (running),
    .cpu_halted(cpu_halted),
    .ce_count  (ce_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cpu_ce pulse must match the oldest expectation
  always begin
    @(posedge clk);
    #1;
    if (cpu_ce === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ce actual=1 required=0 at cyc %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ce_cycle", cyc, e.cyc);
        chk("ce_count_at_pulse", 32'(ce_count), 32'(e.cnt));
      end
    end
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One slow_clk period (8 high, 8 low); rise optionally coincides with halt_req
  task automatic slow_period(input bit expect_ce, input bit with_halt);
    exp_t e;
    @(negedge clk);
    slow_clk = 1'b1;
    halt_req = with_halt;
    if (expect_ce) begin
      e.cyc = cyc + 1;
      e.cnt = exp_count;
      sb.push_back(e);
      exp_count = exp_count + 4'd1;
    end
    @(negedge clk);
    halt_req = 1'b0;
    edges(7);
    slow_clk = 1'b0;
    edges(8);
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    exp_count = 4'd0;
    rst       = 1'b1;
    slow_clk  = 1'b0;
    run_sw    = 1'b1;
    step_btn  = 1'b0;
    halt_req  = 1'b0;

    // Reset with run switch already on
    sample();
    chk("rst_cpu_ce", 32'(cpu_ce), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    sample();
    chk("rst_halted", 32'(cpu_halted), 32'd0);
    chk("rst_ce_count", 32'(ce_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sample();
    sample();
    chk("run_after_2_edges", 32'(running), 32'd0);
    sample();
    chk("run_after_3_edges", 32'(running), 32'd1);

    // Free run: ten slow periods, ten pulses
    for (int i = 0; i < 10; i++) slow_period(1'b1, 1'b0);
    edges(2);
    chk("run_ce_count", 32'(ce_count), 32'd10);
    chk("run_pending", 32'(sb.size()), 32'd0);

    // Single step with a bouncing button
    run_sw = 1'b0;
    edges(6);
    chk("halt_after_run_off", 32'(running), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step_btn = ~step_btn;
      edges(2);
    end
    step_btn = 1'b1;
    edges(20);
    step_btn = 1'b0;
    edges(12);
    slow_period(1'b1, 1'b0);
    slow_period(1'b0, 1'b0);
    chk("step_running", 32'(running), 32'd0);
    chk("step_ce_count", 32'(ce_count), 32'd11);
    chk("step_pending", 32'(sb.size()), 32'd0);

    // HLT coinciding with a tick: halt wins
    run_sw = 1'b1;
    edges(6);
    chk("hlt_pre_running", 32'(running), 32'd1);
    slow_period(1'b0, 1'b1);
    chk("hlt_halted", 32'(cpu_halted), 32'd1);
    chk("hlt_running", 32'(running), 32'd0);
    slow_period(1'b0, 1'b0);
    chk("hlt_stays_halted", 32'(running), 32'd0);
    run_sw = 1'b0;
    edges(6);
    chk("hlt_rearm_clear", 32'(cpu_halted), 32'd0);
    run_sw = 1'b1;
    edges(6);
    chk("hlt_resume", 32'(running), 32'd1);
    slow_period(1'b1, 1'b0);
    chk("hlt_ce_count", 32'(ce_count), 32'd12);

    // Counter wrap 15 -> 0
    for (int i = 0; i < 4; i++) slow_period(1'b1, 1'b0);
    chk("wrap_zero", 32'(ce_count), 32'd0);
    slow_period(1'b1, 1'b0);
    chk("wrap_one", 32'(ce_count), 32'd1);

    // Reset while in STEP: no pulse afterwards
    run_sw = 1'b0;
    edges(6);
    step_btn = 1'b1;
    edges(12);
    rst      = 1'b1;
    step_btn = 1'b0;
    edges(2);
    chk("mid_step_rst_count", 32'(ce_count), 32'd0);
    chk("mid_step_rst_running", 32'(running), 32'd0);
    rst = 1'b0;
    exp_count = 4'd0;
    edges(12);
    slow_period(1'b0, 1'b0);
    chk("post_rst_count", 32'(ce_count), 32'd0);
    chk("post_rst_running", 32'(running), 32'd0);
    chk("final_pending", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
